// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response, decode handoff.
// Latency: n/a (wires only).
// Backpressure: imem_gnt stalls requests, if_ready stalls the decode handoff.
interface fetch_unit_if #(
  parameter int W = 32
);
  // Redirect from the PC-source mux
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;

  // Instruction memory request/response
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  // Handoff to decode
  logic         if_valid;
  logic         if_ready;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  if_ready,
    output imem_req, imem_addr,
    output if_valid, if_pc, if_instr
  );

  // Environment side (memory, decode, redirect source)
  modport slave (
    output redirect_valid, redirect_pc,
    output imem_gnt, imem_rvalid, imem_rdata,
    output if_ready,
    input  imem_req, imem_addr,
    input  if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry holding slot toward decode.
// Latency: request -> if_valid is gnt cycle + rvalid cycle; 3 cycles/instr at zero-latency memory.
// Backpressure: if_ready low holds the slot and blocks new requests; imem_gnt low holds the request.
module fetch_unit #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam logic [W-1:0] PC_STEP = W'(4);

  // REQ : request driven, waiting for grant
  // WAIT: granted, waiting for the response we want
  // HOLD: instruction presented to decode
  // DROP: granted, but the response belongs to a stale path and is thrown away
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] if_pc_q, if_pc_d;
  logic [W-1:0] if_instr_q, if_instr_d;

  // Redirect targets are word aligned regardless of what the mux sends.
  logic [W-1:0] redirect_tgt;
  assign redirect_tgt = {bus.redirect_pc[W-1:2], 2'b00};

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Next-state and pc update; redirect takes precedence over the sequential pc+4.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    unique case (state_q)
      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
          // A grant this cycle means the old address is already in flight.
          state_d = bus.imem_gnt ? ST_DROP : ST_REQ;
        end else if (bus.imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
          // Data arriving with the redirect is stale; otherwise drain it later.
          state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        end else if (bus.imem_rvalid) begin
          if_pc_d    = pc_q;
          if_instr_d = bus.imem_rdata;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (bus.if_ready) begin
          state_d = ST_REQ;
        end
      end

      ST_DROP: begin
        if (bus.redirect_valid) begin
          // Still owe the memory one response; just retarget the pc.
          pc_d = redirect_tgt;
        end else if (bus.imem_rvalid) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Outputs are gated by rst so nothing is requested or presented while in reset.
  assign bus.imem_req  = (state_q == ST_REQ) && !rst;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (state_q == ST_HOLD) && !rst;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.W(32)) bus0 ();
  fetch_unit_if #(.W(32)) bus1 ();

  fetch_unit #(.W(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fetch_unit #(.W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Second instance: zero-latency memory, decode always ready, no redirects.
  logic rv1;
  assign bus1.redirect_valid = 1'b0;
  assign bus1.redirect_pc    = 32'h0;
  assign bus1.imem_gnt       = bus1.imem_req;
  assign bus1.imem_rvalid    = rv1;
  assign bus1.imem_rdata     = 32'h0000_0013;
  assign bus1.if_ready       = 1'b1;
  always @(posedge clk) rv1 <= !rst && bus1.imem_req && bus1.imem_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pc to fetch next, one outstanding request (possibly stale),
  // and a one-entry slot holding the instruction offered to decode.
  logic [31:0] m_pc, n_pc;
  logic        m_out, n_out;
  logic        m_stale, n_stale;
  logic        m_slot_v, n_slot_v;
  logic [31:0] m_slot_pc, n_slot_pc;
  logic [31:0] m_slot_ins, n_slot_ins;
  logic        m_req, m_accept, m_deliver;

  always_comb begin
    n_pc       = m_pc;
    n_out      = m_out;
    n_stale    = m_stale;
    n_slot_v   = m_slot_v;
    n_slot_pc  = m_slot_pc;
    n_slot_ins = m_slot_ins;
    m_req      = !m_out && !m_slot_v;
    m_accept   = m_req && bus0.imem_gnt;
    m_deliver  = m_out && bus0.imem_rvalid;
    if (rst) begin
      n_pc       = 32'h0;
      n_out      = 1'b0;
      n_stale    = 1'b0;
      n_slot_v   = 1'b0;
      n_slot_pc  = 32'h0;
      n_slot_ins = 32'h0;
    end else begin
      if (m_slot_v && (bus0.if_ready || bus0.redirect_valid)) n_slot_v = 1'b0;
      if (m_deliver) begin
        n_out   = 1'b0;
        n_stale = 1'b0;
        if (!m_stale && !bus0.redirect_valid) begin
          n_slot_v   = 1'b1;
          n_slot_pc  = m_pc;
          n_slot_ins = bus0.imem_rdata;
          n_pc       = m_pc + 32'd4;
        end
      end
      if (m_accept) begin
        n_out   = 1'b1;
        n_stale = bus0.redirect_valid;
      end
      if (bus0.redirect_valid) begin
        n_pc = bus0.redirect_pc & 32'hFFFF_FFFC;
        if (n_out) n_stale = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    m_pc       <= n_pc;
    m_out      <= n_out;
    m_stale    <= n_stale;
    m_slot_v   <= n_slot_v;
    m_slot_pc  <= n_slot_pc;
    m_slot_ins <= n_slot_ins;
  end

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_imem_req", 32'(bus0.imem_req), 32'd0);
        check("rst_if_valid", 32'(bus0.if_valid), 32'd0);
      end else begin
        check("model_imem_req", 32'(bus0.imem_req), 32'(m_req));
        if (m_req) check("model_imem_addr", bus0.imem_addr, m_pc);
        check("model_if_valid", 32'(bus0.if_valid), 32'(m_slot_v));
        if (m_slot_v) begin
          check("model_if_pc", bus0.if_pc, m_slot_pc);
          check("model_if_instr", bus0.if_instr, m_slot_ins);
        end
      end
    end
  end

  // One clock of stimulus: inputs applied just after a rising edge, held through the next.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic rdir, input logic [31:0] rpc);
    bus0.imem_gnt       = g;
    bus0.imem_rvalid    = rv;
    bus0.imem_rdata     = rd;
    bus0.if_ready       = rdy;
    bus0.redirect_valid = rdir;
    bus0.redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus0.imem_gnt       = 1'b0;
    bus0.imem_rvalid    = 1'b0;
    bus0.imem_rdata     = 32'h0;
    bus0.if_ready       = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_imem_req", 32'(bus0.imem_req), 32'd0);
    check("reset_if_valid", 32'(bus0.if_valid), 32'd0);
    check("reset_if_pc", bus0.if_pc, 32'h0);
    check("reset_if_instr", bus0.if_instr, 32'h0);
    rst = 1'b0;
    #1;
    check("first_req", 32'(bus0.imem_req), 32'd1);
    check("first_addr", bus0.imem_addr, 32'h0);
    check("wrap_first_addr", bus1.imem_addr, 32'hFFFF_FFFC);

    // Basic fetch: gnt immediately, rvalid next cycle
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wait_no_req", 32'(bus0.imem_req), 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    check("fetch_if_valid", 32'(bus0.if_valid), 32'd1);
    check("fetch_if_pc", bus0.if_pc, 32'h0);
    check("fetch_if_instr", bus0.if_instr, 32'h0000_0013);
    check("model_pc_after_fetch", m_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("consume_if_valid", 32'(bus0.if_valid), 32'd0);
    check("next_addr", bus0.imem_addr, 32'h4);
    check("wrap_next_addr", bus1.imem_addr, 32'h0);

    // Decode stall for 5 cycles in HOLD
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("stall_if_valid", 32'(bus0.if_valid), 32'd1);
      check("stall_if_pc", bus0.if_pc, 32'h4);
      check("stall_if_instr", bus0.if_instr, 32'hDEAD_BEEF);
      check("stall_no_req", 32'(bus0.imem_req), 32'd0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("after_stall_addr", bus0.imem_addr, 32'h8);

    // Redirect during WAIT, stale data 2 cycles later
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
    idle();
    check("drop_no_req", 32'(bus0.imem_req), 32'd0);
    cyc(1'b0, 1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 32'h0);
    check("drop_if_valid", 32'(bus0.if_valid), 32'd0);
    check("drop_next_req", 32'(bus0.imem_req), 32'd1);
    check("drop_next_addr", bus0.imem_addr, 32'h0000_0100);

    // Redirect in HOLD together with if_ready
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    check("hold_if_pc", bus0.if_pc, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    check("hold_redir_if_valid", 32'(bus0.if_valid), 32'd0);
    check("hold_redir_addr", bus0.imem_addr, 32'h200);

    // Grant withheld for 10 cycles
    for (int i = 0; i < 10; i++) begin
      idle();
      check("nogrant_req", 32'(bus0.imem_req), 32'd1);
      check("nogrant_addr", bus0.imem_addr, 32'h200);
    end

    // Redirects in REQ (with/without gnt) and in DROP
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0303);
    check("req_redir_addr", bus0.imem_addr, 32'h300);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0400);
    check("req_gnt_redir_drop", 32'(bus0.imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0404);
    check("drop_redir_no_req", 32'(bus0.imem_req), 32'd0);
    cyc(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    check("drop_redir_addr", bus0.imem_addr, 32'h404);
    check("drop_redir_if_valid", 32'(bus0.if_valid), 32'd0);

    // Reset in the middle of WAIT, then a late rvalid in REQ
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(bus0.imem_req), 32'd1);
    check("midrst_addr", bus0.imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    check("late_rvalid_req", 32'(bus0.imem_req), 32'd1);
    check("late_rvalid_addr", bus0.imem_addr, 32'h0);
    check("late_rvalid_if_valid", 32'(bus0.if_valid), 32'd0);

    // Redirect in WAIT with rvalid in the same cycle
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 32'h0000_0501);
    check("wait_rv_redir_if_valid", 32'(bus0.if_valid), 32'd0);
    check("wait_rv_redir_addr", bus0.imem_addr, 32'h500);

    // Back-to-back fetches at 3 cycles each, with stray gnt/rvalid in HOLD
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 32'h0);
      check("stream_if_valid", 32'(bus0.if_valid), 32'd1);
      check("stream_if_pc", bus0.if_pc, 32'h500 + 32'(4 * i));
      check("stream_if_instr", bus0.if_instr, 32'hA0 + 32'(i));
      cyc(1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0);
    end
    check("stream_end_addr", bus0.imem_addr, 32'h510);
    check("stream_end_req", 32'(bus0.imem_req), 32'd1);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
